regfile_wb: RTL and testbench
=============================

REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL expose the following ports (name, direction, width, meaning):
- CLK  input  1  sole clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- wb_valid  input  1  writeback write strobe, driven alongside rd_sel/rd_data.
- wb_rd_sel  input  5  destination register (regbits_t) from writeback.
- wb_rd_data  input  32  destination data (word_t) from writeback.
- issue_valid  input  1  instruction issue attempt.
- issue_rd_en  input  1  issued instruction writes a register.
- issue_rd  input  5  destination of issued instruction.
- flush  input  1  squash all in-flight destinations.
- rs1_sel, rs2_sel  input  5  read-port selects.
- rs1_data, rs2_data  output  32  read data, combinational.
- rs1_ready, rs2_ready  output  1  source has no outstanding write.
- issue_stall  output  1  issue refused this cycle, combinational.
- pending_cnt  output  6  number of set pending bits, registered.
- err_spurious  output  1  sticky: writeback hit a non-pending register.

Function
REQ-003 Storage SHALL be 32 x 32-bit registers; x0 reads 0 always; writes and issues to x0 SHALL be ignored (no pending, no error).
REQ-004 On rising edge with wb_valid=1 and wb_rd_sel!=0, reg[wb_rd_sel] SHALL take wb_rd_data and pending[wb_rd_sel] SHALL clear.
REQ-005 Reads SHALL bypass: if wb_valid=1, wb_rd_sel==rsN_sel, rsN_sel!=0, then rsN_data=wb_rd_data in the same cycle; otherwise rsN_data=reg[rsN_sel].
REQ-006 rsN_ready SHALL be 1 when rsN_sel==0, or pending[rsN_sel]=0, or a same-cycle bypass per REQ-005 applies.
REQ-007 issue_stall SHALL be 1 iff issue_valid & issue_rd_en & issue_rd!=0 & pending[issue_rd] & !(wb_valid & wb_rd_sel==issue_rd) & !flush.
REQ-008 Accepted issue (issue_valid & issue_rd_en & issue_rd!=0 & !issue_stall & !flush) SHALL set pending[issue_rd] at the next edge.
REQ-009 Same-cycle writeback and accepted issue to the same register: the data write SHALL occur and pending SHALL end set (issue wins).
REQ-010 flush=1 SHALL clear all pending bits at the next edge and suppress any same-cycle issue; a same-cycle writeback data write SHALL still occur.
REQ-011 Writeback with wb_valid=1, wb_rd_sel!=0, pending[wb_rd_sel]=0 SHALL still write data and SHALL set err_spurious (sticky until reset).
REQ-012 pending_cnt SHALL equal the population count of the pending bits after each edge (range 0..31, no wrap).
REQ-013 Write latency SHALL be one cycle; a read without bypass of a register written at edge N SHALL return new data from cycle N onward.

Reset
REQ-014 While RST=1 at an edge: all registers SHALL become 0, all pending bits 0, pending_cnt 0, err_spurious 0; issue and writeback in that cycle SHALL be ignored.
REQ-015 Reset asserted with pending writes outstanding SHALL discard them; a later writeback to those registers SHALL set err_spurious.
REQ-016 Combinational outputs after reset: rsN_data=0, rsN_ready=1, issue_stall=0.

Verification
REQ-017 Issue rd=5, next cycle read rs1_sel=5 -> rs1_ready=0, pending_cnt=1; wb x5=0xDEADBEEF -> same cycle rs1_data=0xDEADBEEF, rs1_ready=1; next cycle pending_cnt=0.
REQ-018 x7 pending, issue rd=7 without wb -> issue_stall=1, pending_cnt unchanged; repeat with wb x7 same cycle -> issue_stall=0, x7 pending after edge, data updated.
REQ-019 wb_valid with wb_rd_sel=0, data 0x1234 -> rs1_sel=0 reads 0, err_spurious stays 0; issue rd=0 -> issue_stall=0, pending_cnt=0.
REQ-020 Issue rd=3,4,9 on consecutive cycles, then flush plus wb x4=0x55 same cycle -> pending_cnt=0 next cycle, reg4=0x55, err_spurious=0; later wb x9 -> err_spurious=1.
REQ-021 Issue rd 1..31 across 31 cycles -> pending_cnt=31, no wrap; assert RST mid-sequence -> all outputs at REQ-014/016 values next cycle.

Source files
------------

// File: rtl/regfile_wb.sv
// 32x32 register file with writeback bypass, per-register pending (scoreboard) bits and issue stall.
// Reads, bypass, ready and stall are combinational; storage, pending, pending_cnt and err_spurious update on CLK.
module regfile_wb (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd_sel,
  input  logic [31:0] wb_rd_data,
  input  logic        issue_valid,
  input  logic        issue_rd_en,
  input  logic [4:0]  issue_rd,
  input  logic        flush,
  input  logic [4:0]  rs1_sel,
  input  logic [4:0]  rs2_sel,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        rs1_ready,
  output logic        rs2_ready,
  output logic        issue_stall,
  output logic [5:0]  pending_cnt,
  output logic        err_spurious
);

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  word_t       regs [32];
  logic [31:0] pending;
  logic [31:0] pending_nxt;

  logic wb_hit;
  logic issue_req;
  logic issue_accept;
  logic rs1_bypass;
  logic rs2_bypass;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  assign wb_hit    = wb_valid && (wb_rd_sel != regbits_t'(0));
  assign issue_req = issue_valid && issue_rd_en && (issue_rd != regbits_t'(0));

  // A writeback retiring the same register in this cycle frees it for re-issue.
  assign issue_stall  = issue_req && pending[issue_rd]
                        && !(wb_valid && (wb_rd_sel == issue_rd)) && !flush;
  assign issue_accept = issue_req && !issue_stall && !flush;

  assign rs1_bypass = wb_hit && (wb_rd_sel == rs1_sel);
  assign rs2_bypass = wb_hit && (wb_rd_sel == rs2_sel);

  always_comb begin
    rs1_data = '0;
    if (rs1_bypass)                    rs1_data = wb_rd_data;
    else if (rs1_sel != regbits_t'(0)) rs1_data = regs[rs1_sel];
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_bypass)                    rs2_data = wb_rd_data;
    else if (rs2_sel != regbits_t'(0)) rs2_data = regs[rs2_sel];
  end

  assign rs1_ready = (rs1_sel == regbits_t'(0)) || !pending[rs1_sel] || rs1_bypass;
  assign rs2_ready = (rs2_sel == regbits_t'(0)) || !pending[rs2_sel] || rs2_bypass;

  // Order matters: issue overrides a same-register writeback clear, flush overrides everything.
  always_comb begin
    pending_nxt = pending;
    if (wb_hit)       pending_nxt[wb_rd_sel] = 1'b0;
    if (issue_accept) pending_nxt[issue_rd]  = 1'b1;
    if (flush)        pending_nxt            = '0;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      pending      <= '0;
      pending_cnt  <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (wb_hit) regs[wb_rd_sel] <= wb_rd_data;
      pending     <= pending_nxt;
      pending_cnt <= popcount(pending_nxt);
      if (wb_hit && !pending[wb_rd_sel]) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: stimulus pushes hand-computed expectations into a queue, a monitor checks them.
module tb_regfile_wb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        wb_valid;
  logic [4:0]  wb_rd_sel;
  logic [31:0] wb_rd_data;
  logic        issue_valid;
  logic        issue_rd_en;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [4:0]  rs1_sel;
  logic [4:0]  rs2_sel;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_ready;
  logic        rs2_ready;
  logic        issue_stall;
  logic [5:0]  pending_cnt;
  logic        err_spurious;

  regfile_wb dut (
    .CLK(CLK), .RST(RST),
    .wb_valid(wb_valid), .wb_rd_sel(wb_rd_sel), .wb_rd_data(wb_rd_data),
    .issue_valid(issue_valid), .issue_rd_en(issue_rd_en), .issue_rd(issue_rd),
    .flush(flush), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .issue_stall(issue_stall), .pending_cnt(pending_cnt), .err_spurious(err_spurious)
  );

  always #5 CLK = ~CLK;

  typedef enum int {S_RS1D, S_RS2D, S_RS1R, S_RS2R, S_STALL, S_CNT, S_ERR} sig_e;

  typedef struct {
    int          cyc;
    string       name;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_RS1D:  return rs1_data;
      S_RS2D:  return rs2_data;
      S_RS1R:  return 32'(rs1_ready);
      S_RS2R:  return 32'(rs2_ready);
      S_STALL: return 32'(issue_stall);
      S_CNT:   return 32'(pending_cnt);
      default: return 32'(err_spurious);
    endcase
  endfunction

  // Monitor: every falling edge, compare all expectations due in this cycle.
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] got;
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s missed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
      end else begin
        got = sample(e.sig);
        if (got !== e.val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, cyc, got, e.val);
        end
      end
    end
  end

  task automatic ex(input string name, input sig_e s, input logic [31:0] v, input int ofs);
    exp_t e;
    e.cyc = cyc + ofs; e.name = name; e.sig = s; e.val = v;
    q.push_back(e);
  endtask

  // Advance to the next cycle and drive all inputs idle.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
    RST = 1'b0; wb_valid = 1'b0; wb_rd_sel = '0; wb_rd_data = '0;
    issue_valid = 1'b0; issue_rd_en = 1'b0; issue_rd = '0; flush = 1'b0;
    rs1_sel = '0; rs2_sel = '0;
  endtask

  task automatic do_issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = rd;
  endtask

  task automatic do_wb(input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1'b1; wb_rd_sel = rd; wb_rd_data = d;
  endtask

  initial begin
    RST = 1'b1; wb_valid = 1'b0; wb_rd_sel = '0; wb_rd_data = '0;
    issue_valid = 1'b0; issue_rd_en = 1'b0; issue_rd = '0; flush = 1'b0;
    rs1_sel = '0; rs2_sel = '0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    // Reset state
    next_cycle();
    rs1_sel = 5'd3; rs2_sel = 5'd0;
    ex("rst_rs1_data", S_RS1D, 32'h0, 0);
    ex("rst_rs1_ready", S_RS1R, 1, 0);
    ex("rst_rs2_ready", S_RS2R, 1, 0);
    ex("rst_stall", S_STALL, 0, 0);
    ex("rst_cnt", S_CNT, 0, 0);
    ex("rst_err", S_ERR, 0, 0);

    // Issue x5, read not ready, writeback bypass, then cleared
    next_cycle();
    do_issue(5'd5);
    ex("iss5_stall", S_STALL, 0, 0);
    next_cycle();
    rs1_sel = 5'd5;
    ex("x5_not_ready", S_RS1R, 0, 0);
    ex("x5_cnt1", S_CNT, 1, 0);
    next_cycle();
    rs1_sel = 5'd5; do_wb(5'd5, 32'hDEADBEEF);
    ex("x5_bypass_data", S_RS1D, 32'hDEADBEEF, 0);
    ex("x5_bypass_ready", S_RS1R, 1, 0);
    ex("x5_cnt0", S_CNT, 0, 1);
    next_cycle();
    rs1_sel = 5'd5;
    ex("x5_stored_data", S_RS1D, 32'hDEADBEEF, 0);
    ex("x5_err0", S_ERR, 0, 0);

    // x7 pending: stall without writeback, no stall with writeback
    next_cycle();
    do_issue(5'd7);
    next_cycle();
    do_issue(5'd7);
    ex("x7_stall", S_STALL, 1, 0);
    ex("x7_cnt_before", S_CNT, 1, 0);
    ex("x7_cnt_after_stall", S_CNT, 1, 1);
    next_cycle();
    do_issue(5'd7); do_wb(5'd7, 32'h0000_0077); rs2_sel = 5'd7;
    ex("x7_wb_nostall", S_STALL, 0, 0);
    ex("x7_bypass_data", S_RS2D, 32'h77, 0);
    ex("x7_bypass_ready", S_RS2R, 1, 0);
    ex("x7_cnt_reissue", S_CNT, 1, 1);
    next_cycle();
    rs2_sel = 5'd7;
    ex("x7_pending_again", S_RS2R, 0, 0);
    ex("x7_data_updated", S_RS2D, 32'h77, 0);
    ex("x7_err0", S_ERR, 0, 0);
    next_cycle();
    do_wb(5'd7, 32'h70);
    ex("x7_retired_cnt", S_CNT, 0, 1);

    // x0 is hardwired: no write, no error, no pending
    next_cycle();
    do_wb(5'd0, 32'h1234); rs1_sel = 5'd0;
    ex("x0_read", S_RS1D, 0, 0);
    ex("x0_ready", S_RS1R, 1, 0);
    ex("x0_wb_err", S_ERR, 0, 1);
    next_cycle();
    do_issue(5'd0);
    ex("x0_issue_stall", S_STALL, 0, 0);
    ex("x0_issue_cnt", S_CNT, 0, 1);

    // Issue 3,4,9 then flush with same-cycle writeback of x4
    next_cycle(); do_issue(5'd3);
    next_cycle(); do_issue(5'd4);
    next_cycle(); do_issue(5'd9);
    next_cycle();
    ex("three_pending", S_CNT, 3, 0);
    flush = 1'b1; do_wb(5'd4, 32'h55); do_issue(5'd3);
    ex("flush_no_stall", S_STALL, 0, 0);
    ex("flush_cnt0", S_CNT, 0, 1);
    ex("flush_err0", S_ERR, 0, 1);
    next_cycle();
    rs1_sel = 5'd4; rs2_sel = 5'd3;
    ex("flush_wb_data", S_RS1D, 32'h55, 0);
    ex("flush_x3_ready", S_RS2R, 1, 0);
    next_cycle();
    do_wb(5'd9, 32'h99);
    ex("spurious_x9", S_ERR, 1, 1);
    next_cycle();
    ex("err_sticky", S_ERR, 1, 1);

    // Clear sticky error
    next_cycle(); RST = 1'b1;
    next_cycle();
    ex("rst2_err0", S_ERR, 0, 0);

    // Fill all 31 pending bits
    for (int r = 1; r <= 31; r++) begin
      next_cycle();
      do_issue(5'(r));
      if (r == 16) ex("half_cnt", S_CNT, 15, 0);
    end
    next_cycle();
    rs1_sel = 5'd31; rs2_sel = 5'd1; do_issue(5'd12);
    ex("full_cnt31", S_CNT, 31, 0);
    ex("full_rs1_busy", S_RS1R, 0, 0);
    ex("full_rs2_busy", S_RS2R, 0, 0);
    ex("full_stall", S_STALL, 1, 0);
    ex("full_cnt_hold", S_CNT, 31, 1);

    // Reset with everything pending; same-cycle issue/writeback ignored
    next_cycle();
    RST = 1'b1; do_wb(5'd5, 32'hCAFE0000); do_issue(5'd2);
    next_cycle();
    rs1_sel = 5'd5; rs2_sel = 5'd7; do_issue(5'd5);
    ex("rst3_cnt0", S_CNT, 0, 0);
    ex("rst3_err0", S_ERR, 0, 0);
    ex("rst3_rs1_data", S_RS1D, 0, 0);
    ex("rst3_rs2_data", S_RS2D, 0, 0);
    ex("rst3_rs1_ready", S_RS1R, 1, 0);
    ex("rst3_stall0", S_STALL, 0, 0);
    ex("rst3_issue_cnt", S_CNT, 1, 1);
    next_cycle();
    do_wb(5'd20, 32'h20);
    ex("discarded_wb_err", S_ERR, 1, 1);

    next_cycle();
    for (int i = 0; i < 20 && q.size() > 0; i++) next_cycle();
    if (q.size() > 0) begin
      errors += q.size();
      checks += q.size();
      $display("FAIL drain: %0d expectations never checked", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
